// File: rtl/yuv_pkg.sv
// Shared encodings and constants for the YUV planar frame reader.
// The optional monochrome path is selected with YUV_MONO_EN.
package yuv_pkg;

    typedef enum logic [1:0] {
        YUV_444 = 2'd0,
        YUV_422 = 2'd1,
        YUV_420 = 2'd2
    } yuv_mode_e;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } yuv_state_e;

    // Mid-grey sample value: 1 << (width - 1).
    function automatic int unsigned mid_grey(input int unsigned width);
        return 32'd1 << (width - 1);
    endfunction

    // Encoding 2'b11 is not a layout of its own; it falls back to 4:4:4.
    function automatic yuv_mode_e norm_mode(input logic [1:0] m);
        case (m)
            2'd1:    return YUV_422;
            2'd2:    return YUV_420;
            default: return YUV_444;
        endcase
    endfunction

endpackage

// File: rtl/yuv_plane_reader_if.sv
// Signal bundle of the YUV plane reader: frame configuration, memory read port, pixel stream.
// The mono control input exists only when YUV_MONO_EN is defined.
interface yuv_plane_reader_if #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 22,
    parameter int DIM_W  = 12
);
    logic              start;
    logic [DIM_W-1:0]  frame_w;
    logic [DIM_W-1:0]  frame_h;
    logic [1:0]        mode;
    logic [ADDR_W-1:0] y_base;
    logic [ADDR_W-1:0] u_base;
    logic [ADDR_W-1:0] v_base;
`ifdef YUV_MONO_EN
    logic              mono;
`endif
    logic              busy;
    logic              done;
    logic              mem_rd;
    logic [ADDR_W-1:0] mem_y_addr;
    logic [ADDR_W-1:0] mem_u_addr;
    logic [ADDR_W-1:0] mem_v_addr;
    logic [DATA_W-1:0] mem_y_data;
    logic [DATA_W-1:0] mem_u_data;
    logic [DATA_W-1:0] mem_v_data;
    // Pixel stream: a beat transfers on any cycle where out_valid and out_ready are both high;
    // while out_valid is high and out_ready low, out_valid and all out_* stay stable.
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_y;
    logic [DATA_W-1:0] out_u;
    logic [DATA_W-1:0] out_v;
    logic              out_sof;
    logic              out_eol;

    modport master (
        input  start, frame_w, frame_h, mode, y_base, u_base, v_base,
`ifdef YUV_MONO_EN
        input  mono,
`endif
        input  mem_y_data, mem_u_data, mem_v_data, out_ready,
        output busy, done, mem_rd, mem_y_addr, mem_u_addr, mem_v_addr,
        output out_valid, out_y, out_u, out_v, out_sof, out_eol
    );

    modport slave (
        output start, frame_w, frame_h, mode, y_base, u_base, v_base,
`ifdef YUV_MONO_EN
        output mono,
`endif
        output mem_y_data, mem_u_data, mem_v_data, out_ready,
        input  busy, done, mem_rd, mem_y_addr, mem_u_addr, mem_v_addr,
        input  out_valid, out_y, out_u, out_v, out_sof, out_eol
    );
endinterface

// File: rtl/yuv_skid_fifo.sv
// Two-entry FIFO holding returned pixels; push and pop in the same cycle is legal even when full.
module yuv_skid_fifo #(
    parameter int W = 26
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         push_i,
    input  logic [W-1:0] data_i,
    input  logic         pop_i,
    output logic [W-1:0] data_o,
    output logic         full_o,
    output logic         empty_o,
    output logic [1:0]   count_o
);
    logic [W-1:0] mem_q [2];
    logic         wr_ptr_q;
    logic         rd_ptr_q;
    logic [1:0]   count_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_q[0] <= '0;
            mem_q[1] <= '0;
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            count_q  <= 2'd0;
        end else begin
            if (push_i) begin
                mem_q[wr_ptr_q] <= data_i;
                wr_ptr_q        <= ~wr_ptr_q;
            end
            if (pop_i) rd_ptr_q <= ~rd_ptr_q;
            case ({push_i, pop_i})
                2'b10:   count_q <= count_q + 2'd1;
                2'b01:   count_q <= count_q - 2'd1;
                default: count_q <= count_q;
            endcase
        end
    end

    assign data_o  = mem_q[rd_ptr_q];
    assign full_o  = (count_q == 2'd2);
    assign empty_o = (count_q == 2'd0);
    assign count_o = count_q;
endmodule

// File: rtl/yuv_plane_reader.sv
// Walks a planar Y/U/V frame (4:4:4, 4:2:2, 4:2:0) and streams upsampled pixels with sof/eol tags.
// Defining YUV_MONO_EN adds a mono input that suppresses chroma reads and outputs mid-grey chroma.
module yuv_plane_reader
    import yuv_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 22,
    parameter int DIM_W  = 12
) (
    input  logic                clk,
    input  logic                rst_n,
    yuv_plane_reader_if.master  bus,
    output yuv_state_e          dbg_state_o
);
    localparam int FW = 3 * DATA_W + 2;

    yuv_state_e        state_q, state_d;
    yuv_mode_e         mode_q;
    logic [DIM_W-1:0]  w_q, h_q, cw_q, col_q, col_d, row_q, row_d;
    logic [ADDR_W-1:0] yptr_q, yptr_d, crow_q, crow_d, u_base_q, v_base_q;
    logic [ADDR_W-1:0] y_addr_q, u_addr_q, v_addr_q, ccol, u_cur, v_cur;
    logic              inflight_q, sof_tag_q, eol_tag_q, done_q, done_d;
    logic              rd, pop, drained, last_col, last_pix, cfg_zero, accept;
    logic [DIM_W:0]    w_inc;
    logic [DIM_W-1:0]  cw_in;
    logic [2:0]        occ;
    logic [1:0]        count;
    logic              full, empty;
    logic [DATA_W-1:0] push_u, push_v;
    logic [FW-1:0]     push_data, head;

    assign cfg_zero = (bus.frame_w == '0) || (bus.frame_h == '0);
    assign accept   = (state_q == IDLE) && bus.start && !cfg_zero;
    assign w_inc    = {1'b0, bus.frame_w} + {{DIM_W{1'b0}}, 1'b1};
    assign cw_in    = (norm_mode(bus.mode) == YUV_444) ? bus.frame_w : w_inc[DIM_W:1];
    assign last_col = (col_q == w_q - DIM_W'(1));
    assign last_pix = last_col && (row_q == h_q - DIM_W'(1));

    // Pop is counted so that the read slot freed this cycle can be refilled immediately.
    assign pop     = !empty && bus.out_ready;
    assign occ     = 3'(count) + 3'(inflight_q) - 3'(pop);
    assign drained = !inflight_q && (count == {1'b0, pop});

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (bus.start && !cfg_zero) state_d = RUN;
            RUN:     if (rd && last_pix) state_d = DRAIN;
            DRAIN:   if (drained) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        rd     = 1'b0;
        done_d = 1'b0;
        case (state_q)
            IDLE:    done_d = bus.start && cfg_zero;
            RUN:     rd = (occ < 3'd2);
            DRAIN:   done_d = drained;
            default: ;
        endcase
    end

    always_comb begin
        col_d  = col_q;
        row_d  = row_q;
        yptr_d = yptr_q;
        crow_d = crow_q;
        if (accept) begin
            col_d  = '0;
            row_d  = '0;
            yptr_d = bus.y_base;
            crow_d = '0;
        end else if (rd) begin
            yptr_d = yptr_q + ADDR_W'(1);
            if (last_col) begin
                col_d = '0;
                row_d = row_q + DIM_W'(1);
                // 4:2:0 row pairs share one chroma row, so advance only after odd rows.
                if (mode_q != YUV_420 || row_q[0]) crow_d = crow_q + ADDR_W'(cw_q);
            end else begin
                col_d = col_q + DIM_W'(1);
            end
        end
    end

    assign ccol = (mode_q == YUV_444) ? ADDR_W'(col_q) : ADDR_W'(col_q >> 1);

`ifdef YUV_MONO_EN
    localparam int unsigned     GREY_INT = mid_grey(DATA_W);
    localparam logic [DATA_W-1:0] GREY   = GREY_INT[DATA_W-1:0];
    logic mono_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)      mono_q <= 1'b0;
        else if (accept) mono_q <= bus.mono;
    end

    assign u_cur  = mono_q ? u_base_q : u_base_q + crow_q + ccol;
    assign v_cur  = mono_q ? v_base_q : v_base_q + crow_q + ccol;
    assign push_u = mono_q ? GREY : bus.mem_u_data;
    assign push_v = mono_q ? GREY : bus.mem_v_data;
`else
    assign u_cur  = u_base_q + crow_q + ccol;
    assign v_cur  = v_base_q + crow_q + ccol;
    assign push_u = bus.mem_u_data;
    assign push_v = bus.mem_v_data;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mode_q     <= YUV_444;
            w_q        <= '0;
            h_q        <= '0;
            cw_q       <= '0;
            u_base_q   <= '0;
            v_base_q   <= '0;
            col_q      <= '0;
            row_q      <= '0;
            yptr_q     <= '0;
            crow_q     <= '0;
            y_addr_q   <= '0;
            u_addr_q   <= '0;
            v_addr_q   <= '0;
            inflight_q <= 1'b0;
            sof_tag_q  <= 1'b0;
            eol_tag_q  <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            if (accept) begin
                mode_q   <= norm_mode(bus.mode);
                w_q      <= bus.frame_w;
                h_q      <= bus.frame_h;
                cw_q     <= cw_in;
                u_base_q <= bus.u_base;
                v_base_q <= bus.v_base;
            end
            col_q      <= col_d;
            row_q      <= row_d;
            yptr_q     <= yptr_d;
            crow_q     <= crow_d;
            inflight_q <= rd;
            sof_tag_q  <= rd && (col_q == '0) && (row_q == '0);
            eol_tag_q  <= rd && last_col;
            done_q     <= done_d;
            if (rd) begin
                y_addr_q <= yptr_q;
                u_addr_q <= u_cur;
                v_addr_q <= v_cur;
            end
        end
    end

    assign push_data = {sof_tag_q, eol_tag_q, bus.mem_y_data, push_u, push_v};

    yuv_skid_fifo #(.W(FW)) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .push_i  (inflight_q),
        .data_i  (push_data),
        .pop_i   (pop),
        .data_o  (head),
        .full_o  (full),
        .empty_o (empty),
        .count_o (count)
    );

    // The read gate must never let a returning pixel hit a full FIFO that is not draining.
    assert property (@(posedge clk) disable iff (!rst_n) !(inflight_q && full && !pop));

    assign bus.busy       = (state_q != IDLE);
    assign bus.done       = done_q;
    assign bus.mem_rd     = rd;
    assign bus.mem_y_addr = rd ? yptr_q : y_addr_q;
    assign bus.mem_u_addr = rd ? u_cur : u_addr_q;
    assign bus.mem_v_addr = rd ? v_cur : v_addr_q;
    assign bus.out_valid  = !empty;
    assign {bus.out_sof, bus.out_eol, bus.out_y, bus.out_u, bus.out_v} = head;
    assign dbg_state_o    = state_q;
endmodule

// File: tb/tb_yuv_plane_reader.sv
// Directed bench for yuv_plane_reader: memory model, scoreboard queues and stall/flow monitor.
// Honours YUV_MONO_EN for the final frame.
module tb_yuv_plane_reader;
    import yuv_pkg::*;

    localparam int DW = 8;
    localparam int AW = 22;
    localparam int MW = 12;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    yuv_plane_reader_if #(.DATA_W(DW), .ADDR_W(AW), .DIM_W(MW)) bus ();
    yuv_state_e dbg_state;

    yuv_plane_reader #(.DATA_W(DW), .ADDR_W(AW), .DIM_W(MW)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .bus         (bus),
        .dbg_state_o (dbg_state)
    );

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Frame memory: one-cycle synchronous read, data derived from the address.
    always @(posedge clk) begin
        if (bus.mem_rd) begin
            bus.mem_y_data <= bus.mem_y_addr[7:0];
            bus.mem_u_data <= bus.mem_u_addr[7:0] ^ 8'h55;
            bus.mem_v_data <= bus.mem_v_addr[7:0] ^ 8'haa;
        end
    end

    int cyc = 0;
    always @(posedge clk) cyc++;

    logic [25:0]   exp_q[$];
    logic [AW-1:0] exp_y_q[$], exp_u_q[$], exp_v_q[$];
    int            coff[$];
    bit            mon_en = 1'b0;
    int            rd_cnt, pop_cnt, done_cnt, first_pop, last_pop, done_cyc, exp_reads;
    logic [25:0]   prev_pix;
    bit            prev_stall = 1'b0;

    always @(negedge clk) begin
        logic [25:0] pix;
        bit          popn;
        pix  = {bus.out_sof, bus.out_eol, bus.out_y, bus.out_u, bus.out_v};
        popn = bus.out_valid && bus.out_ready;
        if (bus.done) begin
            done_cnt++;
            done_cyc = cyc;
        end
        if (mon_en) begin
            if (prev_stall) begin
                check("stall_valid", 32'(bus.out_valid), 32'd1);
                check("stall_hold", 32'(pix), 32'(prev_pix));
            end
            if (bus.mem_rd) begin
                check("rd_gate", 32'((rd_cnt - pop_cnt - int'(popn)) <= 1), 32'd1);
                if (exp_y_q.size() == 0) begin
                    check("extra_read", 32'(rd_cnt + 1), 32'(exp_reads));
                end else begin
                    check("rd_y_addr", 32'(bus.mem_y_addr), 32'(exp_y_q.pop_front()));
                    check("rd_u_addr", 32'(bus.mem_u_addr), 32'(exp_u_q.pop_front()));
                    check("rd_v_addr", 32'(bus.mem_v_addr), 32'(exp_v_q.pop_front()));
                end
                rd_cnt++;
            end
            if (popn) begin
                if (exp_q.size() == 0) check("extra_pixel", 32'(pop_cnt + 1), 32'(exp_reads));
                else                   check("pixel", 32'(pix), 32'(exp_q.pop_front()));
                if (first_pop < 0) first_pop = cyc;
                last_pop = cyc;
                pop_cnt++;
            end
        end
        prev_stall = mon_en && bus.out_valid && !bus.out_ready;
        prev_pix   = pix;
    end

    task automatic build_exp(input int w, input int h, input logic [AW-1:0] yb,
                             input logic [AW-1:0] ub, input logic [AW-1:0] vb, input bit mono);
        logic [AW-1:0] ya, ua, va;
        logic [7:0]    uo, vo;
        exp_q.delete(); exp_y_q.delete(); exp_u_q.delete(); exp_v_q.delete();
        for (int i = 0; i < w * h; i++) begin
            ya = yb + AW'(i);
            ua = mono ? ub : ub + AW'(coff[i]);
            va = mono ? vb : vb + AW'(coff[i]);
            uo = mono ? 8'h80 : ua[7:0] ^ 8'h55;
            vo = mono ? 8'h80 : va[7:0] ^ 8'haa;
            exp_y_q.push_back(ya);
            exp_u_q.push_back(ua);
            exp_v_q.push_back(va);
            exp_q.push_back({(i == 0), ((i % w) == w - 1), ya[7:0], uo, vo});
        end
        exp_reads = w * h;
    endtask

    task automatic drive_cfg(input int w, input int h, input logic [1:0] mode, input logic [AW-1:0] yb,
                             input logic [AW-1:0] ub, input logic [AW-1:0] vb, input bit mono);
        bus.frame_w = MW'(w);
        bus.frame_h = MW'(h);
        bus.mode    = mode;
        bus.y_base  = yb;
        bus.u_base  = ub;
        bus.v_base  = vb;
`ifdef YUV_MONO_EN
        bus.mono    = mono;
`else
        if (mono) $display("mono request ignored in this build");
`endif
    endtask

    // rdy_mode 0: out_ready high; 1: toggling 1010.. then low for 5 cycles.
    task automatic run_frame(input string name, input int w, input int h, input logic [1:0] mode,
                             input logic [AW-1:0] yb, input logic [AW-1:0] ub, input logic [AW-1:0] vb,
                             input bit mono, input int rdy_mode, input bit poke);
        build_exp(w, h, yb, ub, vb, mono);
        rd_cnt = 0; pop_cnt = 0; done_cnt = 0; first_pop = -1; last_pop = -1; done_cyc = -1;
        mon_en = 1'b1;
        @(posedge clk); #1;
        drive_cfg(w, h, mode, yb, ub, vb, mono);
        bus.start = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0;
        for (int k = 0; k < 300 && done_cnt == 0; k++) begin
            if (rdy_mode == 1) bus.out_ready = (k < 6) ? ((k % 2) == 0) : (k >= 11);
            else               bus.out_ready = 1'b1;
            bus.start = poke && (k == 4);
            if (poke && k == 4) bus.frame_w = MW'(1);
            @(posedge clk); #1;
        end
        bus.start     = 1'b0;
        bus.out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check({name, "_done_once"}, 32'(done_cnt), 32'd1);
        check({name, "_done_after_pop"}, 32'(done_cyc), 32'(last_pop + 1));
        check({name, "_reads"}, 32'(rd_cnt), 32'(w * h));
        check({name, "_pixels"}, 32'(pop_cnt), 32'(w * h));
        check({name, "_exp_left"}, 32'(exp_q.size()), 32'd0);
        check({name, "_busy_after"}, 32'(bus.busy), 32'd0);
        if (rdy_mode == 0) check({name, "_rate"}, 32'(last_pop - first_pop), 32'(w * h - 1));
        mon_en = 1'b0;
    endtask

    task automatic check_quiet(input string name);
        check({name, "_busy"}, 32'(bus.busy), 32'd0);
        check({name, "_done"}, 32'(bus.done), 32'd0);
        check({name, "_mem_rd"}, 32'(bus.mem_rd), 32'd0);
        check({name, "_valid"}, 32'(bus.out_valid), 32'd0);
        check({name, "_y_addr"}, 32'(bus.mem_y_addr), 32'd0);
        check({name, "_out"}, 32'({bus.out_sof, bus.out_eol, bus.out_y, bus.out_u, bus.out_v}), 32'd0);
        check({name, "_state"}, 32'(dbg_state), 32'(IDLE));
    endtask

    initial begin
        int start_cyc;
        bus.start = 1'b0;
        bus.out_ready = 1'b1;
        drive_cfg(0, 0, 2'd0, '0, '0, '0, 1'b0);

        repeat (3) @(posedge clk);
        #1;
        check_quiet("reset");
        rst_n = 1'b1;
        @(posedge clk); #1;
        check_quiet("idle");

        coff = '{0, 1, 2, 3, 4, 5, 6, 7};
        run_frame("f444", 4, 2, 2'd0, 22'h000, 22'h100, 22'h200, 1'b0, 0, 1'b0);
        check("y_addr_hold", 32'(bus.mem_y_addr), 32'h007);
        check("u_addr_hold", 32'(bus.mem_u_addr), 32'h107);

        coff = '{0, 0, 1, 1, 0, 0, 1, 1, 2, 2, 3, 3, 2, 2, 3, 3};
        run_frame("f420", 4, 4, 2'd2, 22'h000, 22'h100, 22'h200, 1'b0, 0, 1'b1);

        coff = '{0, 0, 1, 2, 2, 3};
        run_frame("f422", 3, 2, 2'd1, 22'h000, 22'h100, 22'h200, 1'b0, 0, 1'b0);

        coff = '{0, 1, 2, 3, 4, 5, 6, 7};
        run_frame("stall", 8, 1, 2'd3, 22'h010, 22'h120, 22'h230, 1'b0, 1, 1'b0);

        // Zero width: done the cycle after start, no reads, never busy.
        exp_q.delete(); exp_y_q.delete(); exp_u_q.delete(); exp_v_q.delete();
        exp_reads = 0; rd_cnt = 0; pop_cnt = 0; done_cnt = 0; done_cyc = -1;
        mon_en = 1'b1;
        @(posedge clk); #1;
        drive_cfg(0, 3, 2'd0, 22'h000, 22'h100, 22'h200, 1'b0);
        bus.start = 1'b1;
        start_cyc = cyc;
        @(posedge clk); #1;
        bus.start = 1'b0;
        check("zero_busy", 32'(bus.busy), 32'd0);
        repeat (4) @(posedge clk);
        #1;
        check("zero_done_once", 32'(done_cnt), 32'd1);
        check("zero_done_cycle", 32'(done_cyc), 32'(start_cyc + 1));
        check("zero_reads", 32'(rd_cnt), 32'd0);
        mon_en = 1'b0;

        // Abort a frame with reset, then start a fresh one.
        done_cnt = 0;
        @(posedge clk); #1;
        drive_cfg(4, 4, 2'd2, 22'h000, 22'h100, 22'h200, 1'b0);
        bus.start = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0;
        bus.out_ready = 1'b0;
        repeat (6) @(posedge clk);
        #1;
        check("abort_busy_before", 32'(bus.busy), 32'd1);
        rst_n = 1'b0;
        #1;
        check_quiet("abort_rst");
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        bus.out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("abort_no_done", 32'(done_cnt), 32'd0);

        coff = '{0, 1};
`ifdef YUV_MONO_EN
        run_frame("restart", 2, 1, 2'd0, 22'h040, 22'h140, 22'h240, 1'b1, 0, 1'b0);
`else
        run_frame("restart", 2, 1, 2'd0, 22'h040, 22'h140, 22'h240, 1'b0, 0, 1'b0);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/yuv_plane_reader.md
Name: yuv_plane_reader

Overview:
- Synthesizable successor to the simulation YUV plane memory model.
- Walks a frame stored as three planar Y/U/V buffers and generates read addresses for 4:4:4, 4:2:2 and 4:2:0 layouts.
- Emits one fully upsampled YUV pixel per handshake on a valid/ready stream, with start-of-frame and end-of-line flags.
- Sits between frame memory (1-cycle synchronous read) and the yuv2rgb converter.

Parameters:
- DATA_W, 8: sample width per channel.
- ADDR_W, 22: memory address width; all address arithmetic is modulo 2^ADDR_W.
- DIM_W, 12: width of the frame_w/frame_h and internal column/row counters.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- start  in  1  frame start request; sampled only in IDLE
- frame_w  in  DIM_W  luma width in pixels; latched on accepted start
- frame_h  in  DIM_W  luma height in lines; latched on accepted start
- mode  in  2  00=444, 01=422, 10=420, 11=treated as 444; latched on accepted start
- y_base  in  ADDR_W  Y plane base address; latched on accepted start
- u_base  in  ADDR_W  U plane base address; latched on accepted start
- v_base  in  ADDR_W  V plane base address; latched on accepted start
- busy  out  1  high from the accepted start until done
- done  out  1  one-cycle pulse at frame completion
- mem_rd  out  1  read strobe
- mem_y_addr  out  ADDR_W  Y read address
- mem_u_addr  out  ADDR_W  U read address
- mem_v_addr  out  ADDR_W  V read address
- mem_y_data  in  DATA_W  Y read data, valid the cycle after mem_rd
- mem_u_data  in  DATA_W  U read data, valid the cycle after mem_rd
- mem_v_data  in  DATA_W  V read data, valid the cycle after mem_rd
- out_valid  out  1  pixel available
- out_ready  in  1  downstream accept
- out_y  out  DATA_W  luma sample
- out_u  out  DATA_W  U sample
- out_v  out  DATA_W  V sample
- out_sof  out  1  first pixel of the frame
- out_eol  out  1  last pixel of a line

Behaviour:
- Reset: all outputs 0; FSM in IDLE; FIFO empty; counters cleared. Reset mid-frame aborts the frame, with no done pulse.
- FSM states:
  - IDLE: on start, if frame_w==0 or frame_h==0, pulse done next cycle with no reads and stay IDLE. Otherwise latch the configuration and go to RUN.
  - RUN: issue reads. After the read for pixel (W-1, H-1) go to DRAIN.
  - DRAIN: wait until the FIFO is empty and no read is in flight. Then pulse done, drop busy, and return to IDLE.
- start while busy is ignored.
- Luma address: a running pointer, starting at y_base and incremented by 1 per issued read. The frame is raster-contiguous.
- Chroma row width cw:
  - 444: cw = W.
  - 422 and 420: cw = (W+1)>>1, so odd widths round up.
- Chroma column: 444 uses col; 422 and 420 use col>>1.
- Chroma row pointer crow:
  - Starts at 0; advanced by cw at each end of line.
  - In 420 it advances only after odd rows (rows 1, 3, ...), so row pairs share a chroma row.
- mem_u_addr = u_base + crow + ccol; mem_v_addr = v_base + crow + ccol.
- Flow control:
  - mem_rd is asserted in RUN only when (FIFO occupancy + in-flight reads) < 2.
  - Returned data is written to a 2-entry FIFO the cycle after mem_rd, tagged with sof/eol.
  - Throughput is 1 pixel/cycle when out_ready is held high.
- Output: out_valid = FIFO not empty; out_* are driven from the FIFO head.
  - Data stays stable while out_valid is high and out_ready is low.
  - An entry pops on out_valid & out_ready.
- Simultaneous FIFO push and pop at full occupancy is legal; occupancy is unchanged.
- done is asserted the cycle after the final pixel handshake, or the cycle after the final push if the pop happened in the same cycle.
- mem_*_addr hold their last value when mem_rd is low.

Optional Feature:
- YUV_MONO_EN, defined:
  - Adds input port mono (latched on start).
  - When mono=1, chroma is never addressed: mem_u_addr and mem_v_addr hold u_base and v_base.
  - out_u and out_v are forced to 1<<(DATA_W-1), i.e. 8'h80 at default width.
- YUV_MONO_EN, undefined: no mono port; chroma is always read.

Decomposition:
- Package yuv_pkg holds:
  - mode encodings (YUV_444, YUV_422, YUV_420)
  - FSM state encodings (IDLE, RUN, DRAIN)
  - the mid-grey constant
- Sub-module yuv_skid_fifo: 2-entry FIFO, width 3*DATA_W+2, with push, pop, full, empty and count.

Test Plan:
- 444, W=4, H=2, bases Y=0x000/U=0x100/V=0x200, out_ready=1 -> Y addresses 0..7, U 0x100..0x107; 8 pixels; sof on pixel 0; eol on pixels 3 and 7; done 1 cycle after the last pop.
- 420, W=4, H=4 -> U addresses per row: rows 0 and 1 are 0x100,0x100,0x101,0x101; rows 2 and 3 are 0x102,0x102,0x103,0x103.
- 422, W=3, H=2 -> cw=2; U addresses per row are 0x100,0x100,0x101 then 0x102,0x102,0x103.
- 444, W=8, H=1, out_ready toggling 1010... and then low for 5 cycles -> no pixel lost or duplicated, out_* stable while stalled, mem_rd stops when the FIFO is full.
- start with frame_w=0 -> done pulse next cycle, mem_rd never high. A second start while busy -> ignored.
- Reset asserted mid-frame, then start again with W=2, H=1 -> outputs 0 during reset; the new frame begins at y_base with sof set. With YUV_MONO_EN and mono=1, out_u = out_v = 0x80.
